l2_request_arbiter: RTL and testbench

Two-port arbiter that shares the single L1-side request port of the L2 cache between the instruction L1 and the data L1. Each requester presents a word request. The arbiter picks one, issues it to the L2 as a registered request and holds it until the L2 signals done. It then returns the read data and a one-cycle done pulse to the winner. It sits between the two L1 controllers and the L2 cache top level, and keeps saturating per-port grant counters for the performance path.

---
 rtl/l2_request_arbiter_pkg.sv | 32 +++
 rtl/l2_request_arbiter_arb_grant_counter.sv | 35 +++
 rtl/l2_request_arbiter.sv | 145 ++++++++++++++
 tb/tb_l2_request_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_request_arbiter_pkg
// Brief    : Shared encodings for the L1-to-L2 request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package l2_request_arbiter_pkg;

    localparam int c_BW_WORD_ADDR = 30;

    // Cache identifiers double as arbiter port indices
    localparam int c_ID_CACHE_I = 0;
    localparam int c_ID_CACHE_D = 1;

    localparam logic c_PORT_I = 1'b0;
    localparam logic c_PORT_D = 1'b1;

    localparam string c_POLICY_RR    = "RR";
    localparam string c_POLICY_FIXED = "FIXED";

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_request_arbiter_arb_grant_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_grant_counter
// Brief    : Saturating grant counter with clear (priority) and enable.
// Revision : 1.0 - initial release
// ============================================================================
module arb_grant_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (i_clear) begin
                r_count <= '0;
            end else if (i_inc && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_request_arbiter
// Brief    : Shares the L2 request port between the instruction and data L1s.
// Revision : 1.0 - initial release
// ============================================================================
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter string POLICY  = c_POLICY_RR,
    parameter int    BW_ADDR = c_BW_WORD_ADDR
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [1:0]           req_i,
    input  logic [1:0]           rw_i,
    input  logic [2*BW_ADDR-1:0] add_i,
    input  logic [63:0]          data_i,
    output logic [1:0]           done_o,
    output logic [31:0]          data_o,
    output logic                 busy_o,
    output logic                 l2_req_o,
    output logic                 l2_rw_o,
    output logic [BW_ADDR-1:0]   l2_add_o,
    output logic [31:0]          l2_data_o,
    input  logic                 l2_done_i,
    input  logic [31:0]          l2_data_i,
    output logic [63:0]          grant_cnt_o,
    input  logic                 cnt_clear_i
);

    localparam bit c_FIXED = (POLICY == c_POLICY_FIXED);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic               r_last;
    logic               r_winner;
    logic               r_l2_req;
    logic               r_l2_rw;
    logic [BW_ADDR-1:0] r_l2_add;
    logic [31:0]        r_l2_data;
    logic [31:0]        r_rdata;

    logic               w_tie_winner;
    logic               w_pick;
    logic               w_grant;
    logic               w_capture;
    logic               w_release;
    logic [1:0]         w_inc;
    logic [BW_ADDR-1:0] w_add   [2];
    logic [31:0]        w_wdata [2];

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign w_add[p]   = add_i[p*BW_ADDR +: BW_ADDR];
        assign w_wdata[p] = data_i[p*32 +: 32];
    end

    // On a tie RR hands the grant to the port that did not win last time
    assign w_tie_winner = c_FIXED ? c_PORT_D : ~r_last;
    assign w_pick       = (req_i == 2'b11) ? w_tie_winner : req_i[1];

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        if (enable_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_i) begin
                        w_grant     = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (l2_done_i) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
                ST_RESP: begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_last    <= c_PORT_I;
            r_winner  <= c_PORT_I;
            r_l2_req  <= 1'b0;
            r_l2_rw   <= 1'b0;
            r_l2_add  <= '0;
            r_l2_data <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_winner  <= w_pick;
                r_l2_req  <= 1'b1;
                r_l2_rw   <= rw_i[w_pick];
                r_l2_add  <= w_add[w_pick];
                r_l2_data <= w_wdata[w_pick];
            end
            if (w_capture) begin
                r_rdata  <= l2_data_i;
                r_l2_req <= 1'b0;
            end
            if (w_release) begin
                r_last <= r_winner;
            end
        end
    end

    assign w_inc = {w_grant & w_pick, w_grant & ~w_pick};

    for (genvar p = 0; p < 2; p++) begin : g_cnt
        arb_grant_counter #(
            .WIDTH (32)
        ) u_cnt (
            .clk      (clock_i),
            .rst      (reset_i),
            .i_enable (enable_i),
            .i_clear  (cnt_clear_i),
            .i_inc    (w_inc[p]),
            .o_count  (grant_cnt_o[p*32 +: 32])
        );
    end

    assign done_o    = (enable_i && (r_state == ST_RESP)) ? port_onehot(r_winner) : 2'b00;
    assign busy_o    = (r_state != ST_IDLE);
    assign data_o    = r_rdata;
    assign l2_req_o  = r_l2_req;
    assign l2_rw_o   = r_l2_rw;
    assign l2_add_o  = r_l2_add;
    assign l2_data_o = r_l2_data;

endmodule
`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_request_arbiter
// Brief    : Scoreboard bench for l2_request_arbiter (RR and FIXED instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    localparam int BW = c_BW_WORD_ADDR;

    typedef struct packed {
        logic [1:0]  done;
        logic [31:0] data;
    } exp_t;

    logic          clock_i = 1'b0;
    logic          reset_i, enable_i, l2_done_i, cnt_clear_i;
    logic [1:0]    req_i, rw_i;
    logic [2*BW-1:0] add_i;
    logic [63:0]   data_i;
    logic [31:0]   l2_data_i;

    logic [1:0]    done_o, fx_done_o;
    logic [31:0]   data_o, fx_data_o, l2_data_o, fx_l2_data_o;
    logic          busy_o, fx_busy_o, l2_req_o, fx_l2_req_o, l2_rw_o, fx_l2_rw_o;
    logic [BW-1:0] l2_add_o, fx_l2_add_o;
    logic [63:0]   grant_cnt_o, fx_grant_cnt_o;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   l2_auto = 1'b0;
    int   l2_lat  = 1;
    int   l2_cnt  = 0;

    always #5 clock_i = ~clock_i;

    l2_request_arbiter #(.POLICY("RR"), .BW_ADDR(BW)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
        .rw_i(rw_i), .add_i(add_i), .data_i(data_i), .done_o(done_o), .data_o(data_o),
        .busy_o(busy_o), .l2_req_o(l2_req_o), .l2_rw_o(l2_rw_o), .l2_add_o(l2_add_o),
        .l2_data_o(l2_data_o), .l2_done_i(l2_done_i), .l2_data_i(l2_data_i),
        .grant_cnt_o(grant_cnt_o), .cnt_clear_i(cnt_clear_i)
    );

    l2_request_arbiter #(.POLICY("FIXED"), .BW_ADDR(BW)) dut_fx (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
        .rw_i(rw_i), .add_i(add_i), .data_i(data_i), .done_o(fx_done_o), .data_o(fx_data_o),
        .busy_o(fx_busy_o), .l2_req_o(fx_l2_req_o), .l2_rw_o(fx_l2_rw_o), .l2_add_o(fx_l2_add_o),
        .l2_data_o(fx_l2_data_o), .l2_done_i(l2_done_i), .l2_data_i(l2_data_i),
        .grant_cnt_o(fx_grant_cnt_o), .cnt_clear_i(cnt_clear_i)
    );

    function automatic logic [31:0] l2_resp(input logic [BW-1:0] a);
        return {2'b10, a} ^ 32'h5A5A_0000;
    endfunction

    // Behavioural L2: answers l2_lat cycles after it sees a request
    initial begin
        l2_done_i = 1'b0;
        l2_data_i = '0;
        forever begin
            @(negedge clock_i);
            if (l2_auto) begin
                if (reset_i || l2_done_i) begin
                    l2_done_i = 1'b0;
                    l2_cnt    = 0;
                end else if (l2_req_o) begin
                    l2_cnt++;
                    if (l2_cnt >= l2_lat) begin
                        l2_done_i = 1'b1;
                        l2_data_i = l2_resp(l2_add_o);
                    end
                end
            end
        end
    end

    task automatic wait_done(input int budget, output logic [1:0] d, output logic [31:0] q,
                             output bit timeout);
        timeout = 1'b1;
        d = 2'b00;
        q = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock_i);
            if (done_o !== 2'b00) begin
                d = done_o;
                q = data_o;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i = 1'b1; enable_i = 1'b1; req_i = '0; rw_i = '0; add_i = '0; data_i = '0;
        cnt_clear_i = 1'b0;
        l2_auto = 1'b0; l2_done_i = 1'b0; l2_data_i = '0; l2_cnt = 0;
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (done_o !== 2'b00) $display("FAIL reset_done: got %b want 00", done_o); else n_pass++;
        n_total++; if ({l2_req_o, l2_rw_o, busy_o} !== 3'b000) $display("FAIL reset_ctrl: got req/rw/busy=%b want 000", {l2_req_o, l2_rw_o, busy_o}); else n_pass++;
        n_total++; if (l2_add_o !== '0 || l2_data_o !== '0 || data_o !== '0) $display("FAIL reset_data: got add=%h wdata=%h rdata=%h want 0", l2_add_o, l2_data_o, data_o); else n_pass++;
        n_total++; if (grant_cnt_o !== 64'd0) $display("FAIL reset_cnt: got %h want 0", grant_cnt_o); else n_pass++;
    endtask

    task automatic test_single_read();
        logic [1:0] d; logic [31:0] q; bit to; int high; exp_t e;
        do_reset();
        @(negedge clock_i);
        req_i = 2'b01; rw_i = 2'b00; add_i[0 +: BW] = BW'(32'h100);
        sb.push_back('{done: 2'b01, data: 32'hDEAD_BEEF});
        high = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock_i);
            if (l2_req_o) high++;
            if (c == 0) begin
                n_total++; if (busy_o !== 1'b1) $display("FAIL single_busy: got %b want 1", busy_o); else n_pass++;
                n_total++; if (l2_add_o !== BW'(32'h100) || l2_rw_o !== 1'b0) $display("FAIL single_l2: got add=%h rw=%b want 100/0", l2_add_o, l2_rw_o); else n_pass++;
            end
            if (c == 3) begin l2_done_i = 1'b1; l2_data_i = 32'hDEAD_BEEF; end
        end
        wait_done(10, d, q, to);
        l2_done_i = 1'b0; req_i = 2'b00;
        n_total++; if (to) $display("FAIL single_timeout: got no done want done"); else n_pass++;
        e = sb.pop_front();
        n_total++; if (d !== e.done || q !== e.data) $display("FAIL single_resp: got done=%b data=%h want %b/%h", d, q, e.done, e.data); else n_pass++;
        n_total++; if (high != 4 || l2_req_o !== 1'b0) $display("FAIL single_reqlen: got %0d cycles (now %b) want 4 (now 0)", high, l2_req_o); else n_pass++;
        @(negedge clock_i);
        n_total++; if (done_o !== 2'b00) $display("FAIL single_pulse: got %b want 00", done_o); else n_pass++;
        n_total++; if (grant_cnt_o !== {32'd0, 32'd1}) $display("FAIL single_cnt: got %h want 1", grant_cnt_o); else n_pass++;
    endtask

    task automatic test_rr_vs_fixed();
        logic [1:0] d; logic [31:0] q; bit to; exp_t e; time t_prev;
        logic [BW-1:0] a0, a1;
        do_reset();
        a0 = BW'(32'h150); a1 = BW'(32'h2A0);
        l2_auto = 1'b1; l2_lat = 1;
        @(negedge clock_i);
        req_i = 2'b11; rw_i = 2'b00; add_i = {a1, a0};
        for (int i = 0; i < 4; i++)
            sb.push_back('{done: (i % 2 == 0) ? 2'b10 : 2'b01, data: l2_resp((i % 2 == 0) ? a1 : a0)});
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_done(20, d, q, to);
            if (i == 3) req_i = 2'b00;
            e = sb.pop_front();
            n_total++; if (to || d !== e.done || q !== e.data) $display("FAIL rr_grant%0d: got done=%b data=%h to=%0d want %b/%h", i, d, q, to, e.done, e.data); else n_pass++;
            n_total++; if (fx_done_o !== 2'b10) $display("FAIL fixed_grant%0d: got %b want 10", i, fx_done_o); else n_pass++;
            if (i > 0) begin
                n_total++; if ($time - t_prev != 30) $display("FAIL rr_turnaround%0d: got %0t want 30", i, $time - t_prev); else n_pass++;
            end
            t_prev = $time;
        end
        @(negedge clock_i);
        l2_auto = 1'b0; l2_done_i = 1'b0;
        n_total++; if (grant_cnt_o !== {32'd2, 32'd2}) $display("FAIL rr_cnt: got %h want 2/2", grant_cnt_o); else n_pass++;
        n_total++; if (fx_grant_cnt_o !== {32'd4, 32'd0}) $display("FAIL fixed_cnt: got %h want 4/0", fx_grant_cnt_o); else n_pass++;
    endtask

    task automatic test_enable_stall();
        logic [1:0] d; logic [31:0] q; bit to; exp_t e; bit bad;
        do_reset();
        @(negedge clock_i);
        l2_done_i = 1'b1; l2_data_i = 32'h1111_1111;
        @(negedge clock_i);
        n_total++; if (done_o !== 2'b00 || l2_req_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL idle_done_ignored: got done=%b req=%b busy=%b want 0", done_o, l2_req_o, busy_o); else n_pass++;
        l2_done_i = 1'b0;
        req_i = 2'b10; rw_i = 2'b10; add_i[BW +: BW] = BW'(32'h3F0F); data_i[32 +: 32] = 32'hCAFE_F00D;
        @(negedge clock_i);
        n_total++; if (l2_req_o !== 1'b1 || l2_rw_o !== 1'b1 || l2_add_o !== BW'(32'h3F0F) || l2_data_o !== 32'hCAFE_F00D)
            $display("FAIL write_l2: got req=%b rw=%b add=%h data=%h want 1/1/3f0f/cafef00d", l2_req_o, l2_rw_o, l2_add_o, l2_data_o); else n_pass++;
        req_i = 2'b00; enable_i = 1'b0; l2_done_i = 1'b1; l2_data_i = 32'h2222_2222;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_i);
            if (done_o !== 2'b00 || l2_req_o !== 1'b1 || busy_o !== 1'b1) bad = 1'b1;
            l2_done_i = ~l2_done_i;
        end
        n_total++; if (bad) $display("FAIL stall_hold: got done=%b req=%b want 00/1 throughout", done_o, l2_req_o); else n_pass++;
        enable_i = 1'b1; l2_done_i = 1'b0;
        @(negedge clock_i);
        n_total++; if (done_o !== 2'b00 || l2_req_o !== 1'b1) $display("FAIL stall_resume: got done=%b req=%b want 00/1", done_o, l2_req_o); else n_pass++;
        l2_done_i = 1'b1; l2_data_i = 32'h0BAD_CAFE;
        sb.push_back('{done: 2'b10, data: 32'h0BAD_CAFE});
        wait_done(10, d, q, to);
        l2_done_i = 1'b0;
        e = sb.pop_front();
        n_total++; if (to || d !== e.done || q !== e.data) $display("FAIL stall_resp: got done=%b data=%h to=%0d want %b/%h", d, q, to, e.done, e.data); else n_pass++;
        n_total++; if (grant_cnt_o !== {32'd1, 32'd0}) $display("FAIL stall_cnt: got %h want 1/0", grant_cnt_o); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        logic [1:0] d; logic [31:0] q; bit to; exp_t e; bit seen;
        do_reset();
        @(negedge clock_i);
        req_i = 2'b01; add_i[0 +: BW] = BW'(32'h77);
        @(negedge clock_i);
        reset_i = 1'b1; req_i = 2'b00;
        @(negedge clock_i);
        n_total++; if ({l2_req_o, busy_o, done_o} !== 4'b0000 || l2_add_o !== '0 || grant_cnt_o !== 64'd0)
            $display("FAIL midwait_reset: got req=%b busy=%b done=%b add=%h cnt=%h want 0", l2_req_o, busy_o, done_o, l2_add_o, grant_cnt_o); else n_pass++;
        reset_i = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clock_i); if (done_o !== 2'b00) seen = 1'b1; end
        n_total++; if (seen) $display("FAIL midwait_nodone: got done pulse want none"); else n_pass++;
        l2_auto = 1'b1; l2_lat = 2;
        req_i = 2'b01;
        sb.push_back('{done: 2'b01, data: l2_resp(BW'(32'h77))});
        wait_done(20, d, q, to);
        req_i = 2'b00;
        e = sb.pop_front();
        n_total++; if (to || d !== e.done || q !== e.data) $display("FAIL midwait_fresh: got done=%b data=%h to=%0d want %b/%h", d, q, to, e.done, e.data); else n_pass++;
        @(negedge clock_i);
        l2_auto = 1'b0; l2_done_i = 1'b0;
    endtask

    task automatic test_saturate_clear();
        logic [1:0] d; logic [31:0] q; bit to; exp_t e;
        do_reset();
        l2_auto = 1'b1; l2_lat = 1;
        @(negedge clock_i);
        force dut.g_cnt[0].u_cnt.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.g_cnt[0].u_cnt.r_count;
        #1;
        n_total++; if (grant_cnt_o[31:0] !== 32'hFFFF_FFFF) $display("FAIL sat_preload: got %h want ffffffff", grant_cnt_o[31:0]); else n_pass++;
        @(negedge clock_i);
        req_i = 2'b01; add_i[0 +: BW] = BW'(32'h40);
        sb.push_back('{done: 2'b01, data: l2_resp(BW'(32'h40))});
        wait_done(20, d, q, to);
        req_i = 2'b00;
        e = sb.pop_front();
        n_total++; if (to || d !== e.done || q !== e.data) $display("FAIL sat_resp: got done=%b data=%h to=%0d want %b/%h", d, q, to, e.done, e.data); else n_pass++;
        n_total++; if (grant_cnt_o[31:0] !== 32'hFFFF_FFFF) $display("FAIL sat_hold: got %h want ffffffff", grant_cnt_o[31:0]); else n_pass++;
        repeat (2) @(negedge clock_i);
        req_i = 2'b01; cnt_clear_i = 1'b1;
        sb.push_back('{done: 2'b01, data: l2_resp(BW'(32'h40))});
        @(negedge clock_i);
        cnt_clear_i = 1'b0;
        wait_done(20, d, q, to);
        req_i = 2'b00;
        e = sb.pop_front();
        n_total++; if (to || d !== e.done || q !== e.data) $display("FAIL clr_resp: got done=%b data=%h to=%0d want %b/%h", d, q, to, e.done, e.data); else n_pass++;
        n_total++; if (grant_cnt_o !== 64'd0) $display("FAIL clr_priority: got %h want 0", grant_cnt_o); else n_pass++;
        @(negedge clock_i);
        l2_auto = 1'b0; l2_done_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; enable_i = 1'b1; req_i = '0; rw_i = '0; add_i = '0; data_i = '0;
        cnt_clear_i = 1'b0;
        test_reset();
        test_single_read();
        test_rr_vs_fixed();
        test_enable_stall();
        test_reset_mid_wait();
        test_saturate_clear();
        n_total++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d left want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
